// File: rtl/rob_nwide.sv
// N-wide reorder buffer: in-order dispatch of up to WIDTH instructions, out-of-order
// completion from NUM_WB ports, in-order retire of up to WIDTH. Define ROB_FLUSH_EN for the flush port.

module rob_nwide_checker #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input logic             clk,
    input logic             rst_n,
    input logic [WIDTH-1:0] disp_valid,
    input logic [CNT_W-1:0] count
);
    // Dispatch lanes must form a contiguous run starting at lane 0.
    a_disp_contig: assert property (@(posedge clk) disable iff (!rst_n)
        ((disp_valid & (disp_valid + WIDTH'(1))) == '0));

    a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
        (count <= CNT_W'(DEPTH)));
endmodule

module rob_nwide #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 2,
    parameter int NUM_WB = 3,
    parameter int PREG_W = 6,
    parameter int DATA_W = 32,
    parameter int TAG_W  = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         disp_valid,
    input  logic [WIDTH*PREG_W-1:0]  disp_dest,
    input  logic [WIDTH*PREG_W-1:0]  disp_old_dest,
    output logic                     disp_ready,
    output logic [WIDTH*TAG_W-1:0]   disp_tag,
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*TAG_W-1:0]  wb_tag,
    input  logic [NUM_WB*DATA_W-1:0] wb_data,
    output logic [WIDTH-1:0]         ret_valid,
    output logic [WIDTH*PREG_W-1:0]  ret_dest,
    output logic [WIDTH*PREG_W-1:0]  ret_old_dest,
    output logic [WIDTH*DATA_W-1:0]  ret_data,
    output logic [TAG_W:0]           count
`ifdef ROB_FLUSH_EN
    ,
    input  logic                     flush
`endif
);
    localparam int CNT_W = TAG_W + 1;
    localparam int RN_W  = $clog2(WIDTH + 1);

    function automatic logic [RN_W-1:0] lane_count(input logic [WIDTH-1:0] v);
        logic [RN_W-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + RN_W'(v[i]);
        end
        return n;
    endfunction

    logic [DEPTH-1:0]        valid_r;
    logic [DEPTH-1:0]        done_r;
    logic [PREG_W-1:0]       dest_r     [DEPTH];
    logic [PREG_W-1:0]       old_dest_r [DEPTH];
    logic [DATA_W-1:0]       data_r     [DEPTH];
    logic [TAG_W-1:0]        head_r;
    logic [TAG_W-1:0]        tail_r;
    logic [CNT_W-1:0]        count_r;

    logic [WIDTH-1:0]        ret_valid_r;
    logic [WIDTH*PREG_W-1:0] ret_dest_r;
    logic [WIDTH*PREG_W-1:0] ret_old_dest_r;
    logic [WIDTH*DATA_W-1:0] ret_data_r;

    logic                    flush_s;
    logic                    disp_ready_s;
    logic [WIDTH-1:0]        disp_fire_s;
    logic [RN_W-1:0]         disp_n_s;
    logic [TAG_W-1:0]        disp_idx_s [WIDTH];
    logic [RN_W-1:0]         ret_n_s;
    logic [TAG_W-1:0]        ret_idx_s  [WIDTH];
    logic                    run_s;

`ifdef ROB_FLUSH_EN
    assign flush_s = flush;
`else
    assign flush_s = 1'b0;
`endif

    // Dispatch acceptance uses pre-retire occupancy, so a full group always fits.
    always_comb begin
        disp_tag = '0;
        if (!flush_s && (count_r <= CNT_W'(DEPTH - WIDTH))) begin
            disp_ready_s = 1'b1;
        end else begin
            disp_ready_s = 1'b0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            disp_idx_s[i]                = tail_r + TAG_W'(i);
            disp_fire_s[i]               = disp_ready_s & disp_valid[i];
            disp_tag[i*TAG_W +: TAG_W]   = disp_idx_s[i];
        end
        disp_n_s = lane_count(disp_fire_s);
    end

    // Retire count: leading run of done entries at head, capped by WIDTH and occupancy.
    always_comb begin
        ret_n_s = '0;
        run_s   = !flush_s;
        for (int i = 0; i < WIDTH; i++) begin
            ret_idx_s[i] = head_r + TAG_W'(i);
            if (run_s && (CNT_W'(i) < count_r) && done_r[ret_idx_s[i]]) begin
                ret_n_s = RN_W'(i + 1);
            end else begin
                run_s = 1'b0;
            end
        end
    end

    // Ring pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else if (flush_s) begin
            tail_r  <= head_r;
            count_r <= '0;
        end else begin
            head_r  <= head_r + TAG_W'(ret_n_s);
            tail_r  <= tail_r + TAG_W'(disp_n_s);
            count_r <= count_r + CNT_W'(disp_n_s) - CNT_W'(ret_n_s);
        end
    end

    // Entry state: writeback, then retire clear, then dispatch (last assignment wins).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
            done_r  <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                dest_r[e]     <= '0;
                old_dest_r[e] <= '0;
                data_r[e]     <= '0;
            end
        end else if (flush_s) begin
            valid_r <= '0;
            done_r  <= '0;
        end else begin
            for (int k = 0; k < NUM_WB; k++) begin
                if (wb_valid[k] && valid_r[wb_tag[k*TAG_W +: TAG_W]]) begin
                    done_r[wb_tag[k*TAG_W +: TAG_W]] <= 1'b1;
                    data_r[wb_tag[k*TAG_W +: TAG_W]] <= wb_data[k*DATA_W +: DATA_W];
                end
            end
            for (int i = 0; i < WIDTH; i++) begin
                if (RN_W'(i) < ret_n_s) begin
                    valid_r[ret_idx_s[i]] <= 1'b0;
                    done_r[ret_idx_s[i]]  <= 1'b0;
                end
            end
            for (int i = 0; i < WIDTH; i++) begin
                if (disp_fire_s[i]) begin
                    valid_r[disp_idx_s[i]]    <= 1'b1;
                    done_r[disp_idx_s[i]]     <= 1'b0;
                    dest_r[disp_idx_s[i]]     <= disp_dest[i*PREG_W +: PREG_W];
                    old_dest_r[disp_idx_s[i]] <= disp_old_dest[i*PREG_W +: PREG_W];
                    data_r[disp_idx_s[i]]     <= '0;
                end
            end
        end
    end

    // Registered retire lanes; lanes beyond the retire count are zeroed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ret_valid_r    <= '0;
            ret_dest_r     <= '0;
            ret_old_dest_r <= '0;
            ret_data_r     <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (RN_W'(i) < ret_n_s) begin
                    ret_valid_r[i]                    <= 1'b1;
                    ret_dest_r[i*PREG_W +: PREG_W]     <= dest_r[ret_idx_s[i]];
                    ret_old_dest_r[i*PREG_W +: PREG_W] <= old_dest_r[ret_idx_s[i]];
                    ret_data_r[i*DATA_W +: DATA_W]     <= data_r[ret_idx_s[i]];
                end else begin
                    ret_valid_r[i]                    <= 1'b0;
                    ret_dest_r[i*PREG_W +: PREG_W]     <= '0;
                    ret_old_dest_r[i*PREG_W +: PREG_W] <= '0;
                    ret_data_r[i*DATA_W +: DATA_W]     <= '0;
                end
            end
        end
    end

    assign disp_ready   = disp_ready_s;
    assign ret_valid    = ret_valid_r;
    assign ret_dest     = ret_dest_r;
    assign ret_old_dest = ret_old_dest_r;
    assign ret_data     = ret_data_r;
    assign count        = count_r;

    rob_nwide_checker #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_checker (
        .clk        (clk),
        .rst_n      (rst_n),
        .disp_valid (disp_valid),
        .count      (count_r)
    );
endmodule
